reg_view_ctl: RTL and testbench
===============================

REG_VIEW_CTL -- requirements
Module: reg_view_ctl

Interface
REQ-001 SHALL have parameter ZOOM_MAX, default 4, meaning the highest zoom level reached by the zoom sweep (range 1..7).
REQ-002 SHALL have parameter ZOOM_FRAMES, default 128, meaning the number of frames each zoom level is held.
REQ-003 SHALL have parameter SCAN_FRAMES, default 256, meaning the number of idle frames before an auto-advance (used only with REQ-024).
REQ-004 SHALL have port px_clk, input, 1 bit: pixel clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port endframe, input, 1 bit: end-of-frame level from the VGA stream.
REQ-007 SHALL have ports btn_next and btn_prev, inputs, 1 bit each: raw buttons, active-high.
REQ-008 SHALL have ports src0, src1, src2 and src3, inputs, 16 bits each: candidate register values.
REQ-009 SHALL have port register, output, 16 bits: value shown by the register overlay.
REQ-010 SHALL have port zoom, output, 3 bits: overlay zoom level.
REQ-011 SHALL have port sel, output, 2 bits: index of the displayed source.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-013 SHALL have port led, output, 1 bit: high while the zoom direction is DOWN.

Function
REQ-014 SHALL register endframe and assert frame_tick for exactly one px_clk cycle on each 0->1 transition; all other state SHALL advance only in a frame_tick cycle.
REQ-015 SHALL sample btn_next and btn_prev only at frame_tick, and SHALL act on a press only when the button is high at the current tick and was low at the previous tick (once per press).
REQ-016 A next press SHALL give sel <= sel+1 mod 4, and a prev press SHALL give sel <= sel-1 mod 4; 3->0 and 0->3 wrap.
REQ-017 If next and prev are both pressed at the same tick, sel SHALL remain unchanged.
REQ-018 register SHALL load src[sel_new] only at frame_tick, and SHALL hold between ticks so it never changes mid-frame; the latency from a tick-sampled press to the new value is the same tick.
REQ-019 The zoom FSM SHALL have two states, UP and DOWN; a hold counter SHALL count frames 0..ZOOM_FRAMES-1, and zoom SHALL step when the counter wraps.
REQ-020 In UP the FSM SHALL step zoom by +1; on reaching ZOOM_MAX it SHALL go to DOWN.
REQ-021 In DOWN the FSM SHALL step zoom by -1; on reaching 0 it SHALL go to UP.
REQ-022 The zoom sequence SHALL be 0,1,..,ZOOM_MAX,ZOOM_MAX-1,..,0,1,...; zoom SHALL never leave the range 0..ZOOM_MAX, with no wrap and no repeated endpoint.
REQ-023 led SHALL equal (state == DOWN).

Reset
REQ-025 While rst is high at a px_clk edge, the block SHALL set register=16'h0000, zoom=0, sel=0, frame_tick=0, led=0, state=UP, all counters=0, and previous-button and previous-endframe flags=0.
REQ-026 Reset SHALL override any simultaneous tick or press.
REQ-027 After reset, the first frame_tick SHALL require a fresh 0->1 transition of endframe.

Configuration
REQ-024 With macro REG_VIEW_AUTOSCAN_EN defined, an idle counter SHALL count frame_ticks, and after SCAN_FRAMES ticks with no press it SHALL advance sel by +1 mod 4 and clear itself.
REQ-028 With REG_VIEW_AUTOSCAN_EN defined, any accepted press (REQ-015) SHALL clear the idle counter; if a press and an idle expiry coincide, the press SHALL win.
REQ-029 Without REG_VIEW_AUTOSCAN_EN, the idle counter and auto-advance SHALL be absent, and sel SHALL change only via buttons.

Verification
REQ-030 SHALL cover endframe held high for 5 cycles, then low, then high: frame_tick is high for exactly 1 cycle after each rising edge, 2 pulses in total.
REQ-031 SHALL cover src0..3=1111/2222/3333/4444 with btn_next pressed across 5 separate ticks: sel is 1,2,3,0,1 and register is 2222,3333,4444,1111,2222.
REQ-032 SHALL cover btn_next and btn_prev rising at the same tick while sel=2: sel stays 2; btn_prev alone at sel=0 gives sel=3.
REQ-033 SHALL cover ZOOM_FRAMES=2, ZOOM_MAX=4 over 20 ticks: zoom is 0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0,1,1, and led is high from the tick zoom becomes 4 until it becomes 0.
REQ-034 SHALL cover rst asserted for 1 cycle mid-sweep with zoom=3, sel=2, state=DOWN: the next cycle shows zoom=0, sel=0, register=0000, led=0, and the sweep restarts UP.
REQ-035 SHALL cover, with REG_VIEW_AUTOSCAN_EN and SCAN_FRAMES=4, no presses for 8 ticks: sel goes 0->1 at tick 4 and 1->2 at tick 8; a press at tick 3 delays the auto-advance to tick 7.

Source files
------------

// File: rtl/reg_view_ctl_if.sv
// Register-view overlay bus: frame/button inputs, candidate sources, overlay outputs.
interface reg_view_ctl_if;
  logic        endframe;
  logic        btn_next;
  logic        btn_prev;
  logic [15:0] src0;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [15:0] src3;
  logic [15:0] register;
  logic [2:0]  zoom;
  logic [1:0]  sel;
  logic        frame_tick;
  logic        led;

  modport slave (
    input  endframe, btn_next, btn_prev, src0, src1, src2, src3,
    output register, zoom, sel, frame_tick, led
  );

  modport master (
    output endframe, btn_next, btn_prev, src0, src1, src2, src3,
    input  register, zoom, sel, frame_tick, led
  );
endinterface

// File: rtl/reg_view_ctl.sv
// reg_view_ctl: picks one of four register sources for a VGA overlay, steps a
// ping-pong zoom sweep, and advances everything once per frame.
// Optional feature: define REG_VIEW_AUTOSCAN_EN to auto-advance sel after
// SCAN_FRAMES idle frames.
module reg_view_ctl #(
  parameter int ZOOM_MAX    = 4,
  parameter int ZOOM_FRAMES = 128,
  parameter int SCAN_FRAMES = 256
) (
  input logic           px_clk,
  input logic           rst,
  reg_view_ctl_if.slave bus
);
  localparam int HW = $clog2(ZOOM_FRAMES + 1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} zstate_e;

  generate
    if (ZOOM_MAX < 1 || ZOOM_MAX > 7) begin : g_bad_zoom
      $error("ZOOM_MAX out of range 1..7");
    end
    if (ZOOM_FRAMES < 1 || SCAN_FRAMES < 1) begin : g_bad_frames
      $error("ZOOM_FRAMES and SCAN_FRAMES must be >= 1");
    end
  endgenerate

  logic          ef_q, ef_d, armed_q, armed_d, tick_q, tick_d;
  logic          pn_q, pn_d, pp_q, pp_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   reg_q, reg_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [2:0]    zoom_q, zoom_d;
  zstate_e       st_q, st_d;
  logic          press_n, press_p;

  // Frame edge detect; armed blocks a tick until endframe is seen low after reset.
  always_comb begin
    ef_d    = bus.endframe;
    armed_d = armed_q | ~bus.endframe;
    tick_d  = bus.endframe & ~ef_q & armed_q;
  end

`ifdef REG_VIEW_AUTOSCAN_EN
  localparam int IW = $clog2(SCAN_FRAMES + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  // Button edge detect at frame ticks, sel update and register load.
  always_comb begin
    pn_d    = pn_q;
    pp_d    = pp_q;
    sel_d   = sel_q;
    reg_d   = reg_q;
    press_n = tick_q & bus.btn_next & ~pn_q;
    press_p = tick_q & bus.btn_prev & ~pp_q;
`ifdef REG_VIEW_AUTOSCAN_EN
    idle_d  = idle_q;
`endif
    if (tick_q) begin
      pn_d = bus.btn_next;
      pp_d = bus.btn_prev;
      if (press_n && !press_p)      sel_d = sel_q + 2'd1;
      else if (press_p && !press_n) sel_d = sel_q - 2'd1;
`ifdef REG_VIEW_AUTOSCAN_EN
      // A press (even a cancelling double press) wins over idle expiry.
      if (press_n || press_p) begin
        idle_d = '0;
      end else if (idle_q == IW'(SCAN_FRAMES - 1)) begin
        idle_d = '0;
        sel_d  = sel_q + 2'd1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
`endif
      case (sel_d)
        2'd0:    reg_d = bus.src0;
        2'd1:    reg_d = bus.src1;
        2'd2:    reg_d = bus.src2;
        default: reg_d = bus.src3;
      endcase
    end
  end

  // Zoom ping-pong FSM: hold each level ZOOM_FRAMES ticks, turn at the endpoints.
  always_comb begin
    cnt_d  = cnt_q;
    zoom_d = zoom_q;
    st_d   = st_q;
    if (tick_q) begin
      if (cnt_q == HW'(ZOOM_FRAMES - 1)) begin
        cnt_d = '0;
        case (st_q)
          UP: begin
            zoom_d = zoom_q + 3'd1;
            if (zoom_q + 3'd1 == 3'(ZOOM_MAX)) st_d = DOWN;
          end
          default: begin
            zoom_d = zoom_q - 3'd1;
            if (zoom_q == 3'd1) st_d = UP;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      ef_q    <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
      pn_q    <= 1'b0;
      pp_q    <= 1'b0;
      sel_q   <= 2'd0;
      reg_q   <= 16'h0000;
      cnt_q   <= '0;
      zoom_q  <= 3'd0;
      st_q    <= UP;
`ifdef REG_VIEW_AUTOSCAN_EN
      idle_q  <= '0;
`endif
    end else begin
      ef_q    <= ef_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      pn_q    <= pn_d;
      pp_q    <= pp_d;
      sel_q   <= sel_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      zoom_q  <= zoom_d;
      st_q    <= st_d;
`ifdef REG_VIEW_AUTOSCAN_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign bus.register   = reg_q;
  assign bus.zoom       = zoom_q;
  assign bus.sel        = sel_q;
  assign bus.frame_tick = tick_q;
  assign bus.led        = (st_q == DOWN);
endmodule

// File: tb/tb_reg_view_ctl.sv
// Directed bench for reg_view_ctl (ZOOM_MAX=4, ZOOM_FRAMES=2, SCAN_FRAMES=4).
module tb_reg_view_ctl;
  logic clk, rst;
  int   n_chk, n_pass;
  logic tick_at, led_at;
  logic [2:0] zoom_at;

  reg_view_ctl_if bus ();

  reg_view_ctl #(.ZOOM_MAX(4), .ZOOM_FRAMES(2), .SCAN_FRAMES(4)) dut (
    .px_clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset, then one idle cycle with endframe low so the edge detector arms.
  task automatic do_reset();
    rst = 1'b1; bus.endframe = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // One frame: buttons held across the tick; captures outputs during the tick cycle.
  task automatic do_tick(input logic nx, input logic pv);
    bus.btn_next = nx; bus.btn_prev = pv; bus.endframe = 1'b1;
    cyc();
    tick_at = bus.frame_tick; zoom_at = bus.zoom; led_at = bus.led;
    cyc();
    bus.endframe = 1'b0;
    cyc();
  endtask

  initial begin
    int cnt;
    int zexp [20] = '{0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0,1,1};
    int sexp [5]  = '{1,2,3,0,1};
    logic [15:0] rexp [5] = '{16'h2222,16'h3333,16'h4444,16'h1111,16'h2222};
    logic [1:0] sel34;
    n_chk = 0; n_pass = 0;
    bus.src0 = 16'h1111; bus.src1 = 16'h2222; bus.src2 = 16'h3333; bus.src3 = 16'h4444;
`ifdef REG_VIEW_AUTOSCAN_EN
    sel34 = 2'd3;
`else
    sel34 = 2'd2;
`endif

    // Reset state
    rst = 1'b1; bus.endframe = 1'b1; bus.btn_next = 1'b1; bus.btn_prev = 1'b0;
    cyc();
    chk("rst_reg", bus.register, 16'h0000);
    chk("rst_zoom", bus.zoom, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_tick", bus.frame_tick, 0);
    chk("rst_led", bus.led, 0);

    // endframe high through and after reset: no tick until a fresh rising edge
    rst = 1'b0; cnt = 0;
    repeat (4) begin cyc(); cnt += int'(bus.frame_tick); end
    chk("no_tick_after_rst", cnt, 0);
    bus.endframe = 1'b0; cyc();
    bus.endframe = 1'b1; cyc();
    chk("fresh_edge_tick", bus.frame_tick, 1);

    // Frame tick pulse width: high 5, low, high -> 2 single-cycle pulses
    do_reset(); cnt = 0;
    bus.endframe = 1'b1;
    repeat (5) begin cyc(); cnt += int'(bus.frame_tick); end
    chk("tick_first_window", cnt, 1);
    bus.endframe = 1'b0;
    repeat (3) begin cyc(); cnt += int'(bus.frame_tick); end
    bus.endframe = 1'b1;
    repeat (3) begin cyc(); cnt += int'(bus.frame_tick); end
    chk("tick_total", cnt, 2);

    // Zoom sweep over 20 ticks, values observed during each tick
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_tick(1'b0, 1'b0);
      chk($sformatf("tick_seen%0d", i), tick_at, 1);
      chk($sformatf("zoom%0d", i), zoom_at, zexp[i]);
      chk($sformatf("led%0d", i), led_at, (i >= 8 && i <= 15) ? 1 : 0);
    end

    // Next presses with wrap 3->0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_tick(1'b1, 1'b0);
      chk($sformatf("next_sel%0d", k), bus.sel, sexp[k]);
      chk($sformatf("next_reg%0d", k), bus.register, rexp[k]);
      do_tick(1'b0, 1'b0);
    end

    // Simultaneous next+prev leaves sel; prev from 0 wraps to 3
    do_reset();
    do_tick(1'b1, 1'b0); do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0); do_tick(1'b0, 1'b0);
    chk("pre_both_sel", bus.sel, 2);
    do_tick(1'b1, 1'b1);
    chk("both_sel", bus.sel, 2);
    chk("both_reg", bus.register, 16'h3333);
    do_reset();
    do_tick(1'b0, 1'b1);
    chk("prev_wrap_sel", bus.sel, 3);
    chk("prev_wrap_reg", bus.register, 16'h4444);

    // Held button is acted on once only
    do_tick(1'b0, 1'b1);
    chk("prev_held_sel", bus.sel, 3);

    // Mid-sweep reset with zoom=3 in DOWN
    do_reset();
    for (int i = 0; i < 10; i++) do_tick((i == 0 || i == 2), 1'b0);
    chk("pre34_zoom", bus.zoom, 3);
    chk("pre34_led", bus.led, 1);
    chk("pre34_sel", bus.sel, sel34);
    rst = 1'b1; cyc();
    chk("r34_zoom", bus.zoom, 0);
    chk("r34_sel", bus.sel, 0);
    chk("r34_reg", bus.register, 16'h0000);
    chk("r34_led", bus.led, 0);
    rst = 1'b0; cyc();
    do_tick(1'b0, 1'b0); do_tick(1'b0, 1'b0);
    chk("restart_zoom", bus.zoom, 1);
    chk("restart_led", bus.led, 0);

`ifdef REG_VIEW_AUTOSCAN_EN
    // Idle auto-advance every 4 ticks
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      do_tick(1'b0, 1'b0);
      if (t == 3) chk("as_t3", bus.sel, 0);
      if (t == 4) chk("as_t4", bus.sel, 1);
      if (t == 7) chk("as_t7", bus.sel, 1);
      if (t == 8) chk("as_t8", bus.sel, 2);
    end
    // Press at tick 3 restarts the idle count
    do_reset();
    for (int t = 1; t <= 7; t++) begin
      do_tick((t == 3), 1'b0);
      if (t == 3) chk("asp_t3", bus.sel, 1);
      if (t == 4) chk("asp_t4", bus.sel, 1);
      if (t == 6) chk("asp_t6", bus.sel, 1);
      if (t == 7) chk("asp_t7", bus.sel, 2);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
